recur_job_dispatcher: RTL and testbench
=======================================

Name: recur_job_dispatcher

Overview:
- Front-end stage directly upstream of the recurrence datapath/controller pair.
- Accepts entry requests over valid/ready and buffers them in a small FIFO.
- Launches one computation at a time on the core: drives `entry` and a 1-cycle `start`, waits for the core's `done`, captures the 2*SIZE-bit result and presents it downstream over valid/ready.
- Short-circuits trivial or illegal entries without using the core, and guards against a hung core with a timeout.

Parameters:
- SIZE, 4: entry width; result width is 2*SIZE.
- MAX_ENTRY, 14: largest legal entry; the core memo table holds entries 0..14.
- FIFO_DEPTH, 4: request buffer depth; must be a power of 2.
- PTR_W, 2: log2(FIFO_DEPTH).
- TIMEOUT, 1023: maximum WAIT cycles before the job is aborted.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready; equals !fifo_full.
- in_entry  in  SIZE  requested entry.
- start  out  1  one-cycle launch pulse to the core controller.
- entry  out  SIZE  entry to the core; held stable from LAUNCH until the job completes.
- core_done  in  1  core completion flag.
- core_result  in  2*SIZE  core result; valid while core_done=1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_entry  out  SIZE  entry the result belongs to.
- out_result  out  2*SIZE  result value.
- out_err  out  1  1 = illegal entry or timeout; out_result is then all ones.
- busy  out  1  FSM not in IDLE.
- fifo_count  out  PTR_W+1  occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (rst=0, asynchronous), all outputs low/zero:
  - FIFO pointers and count = 0; FSM = IDLE.
  - start, out_valid, out_err, busy = 0; entry, out_entry, out_result = 0.
  - in_ready becomes 1 on the first clock edge after reset releases.
- FIFO:
  - Push when in_valid & in_ready; pop only from IDLE when the FSM takes a job.
  - Push and pop in the same cycle: count unchanged; allowed whenever count < FIFO_DEPTH.
  - When full, in_ready=0 and in_entry is ignored. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, LAUNCH, GUARD, WAIT, RESULT.
- IDLE: when the FIFO is non-empty and out_valid=0, pop the head. By entry value:
  - head > MAX_ENTRY: load out_result = all ones, out_err=1, out_entry=head; next state RESULT; no start.
  - head is 0 or 1: load out_result = 1, out_err=0; next state RESULT; no start.
  - otherwise: register entry=head; next state LAUNCH.
- LAUNCH: start=1 for exactly this cycle; next state GUARD.
- GUARD: one cycle; core_done is ignored (the core reports done spuriously while its stack is still initial); clear the timeout counter; next state WAIT.
- WAIT: increment the timeout counter each cycle.
  - core_done=1: capture core_result into out_result, out_err=0, out_entry=entry; next state RESULT.
  - counter reaches TIMEOUT with no done: out_result = all ones, out_err=1; next state RESULT.
  - core_done takes priority over timeout when both occur in the same cycle.
- RESULT: out_valid=1 from the cycle after capture.
  - out_result, out_entry and out_err stay stable until out_valid & out_ready.
  - On handshake: out_valid=0 next cycle, FSM returns to IDLE.
- Latency:
  - Trivial or illegal entry: 2 cycles from pop to out_valid.
  - Core job: pop → LAUNCH → GUARD → WAIT (≥1 cycle) → out_valid.
- Concurrency:
  - A new job is never launched while out_valid=1, so at most one job is outstanding.
  - Pushes continue during WAIT/RESULT until the FIFO is full.
- Reset mid-job: the FSM returns to IDLE immediately and queued requests are lost. The core shares rst and must restart cleanly.
- Arithmetic: core_result is passed through unmodified; 2*SIZE-bit wrap inside the core is not flagged.

Decomposition:
- Shared package holds:
  - SIZE, MAX_ENTRY, the result-width constant;
  - the FSM state encoding (3 bits);
  - the ERR_RESULT all-ones constant, shared with the result consumer.
- One natural sub-module: `recur_req_fifo` (parameterised depth, push/pop, count, full/empty); the FSM, timeout counter and output register stay top-level.

Test Plan:
- Push entry 4, out_ready=1, core model returns 41 after 5 WAIT cycles → exactly one start pulse, entry=4 held, out_result=8'd41, out_err=0, out_entry=4.
- Push 0, then 1 → two results of value 1, start never asserted, each out_valid 2 cycles after its pop.
- Push 15 → out_err=1, out_result=8'hFF, no start.
- Push 5 entries back-to-back with core stalled → in_ready=0 after the 4th accept (one job already popped, so after 5 accepts total); fifo_count=4; the 6th request is held off until a pop.
- Core asserts core_done during GUARD and then never again → ignored in GUARD; timeout after 1023 WAIT cycles gives out_err=1, 8'hFF.
- out_ready held 0 for 10 cycles with result 13 (entry 3) → outputs stable, no new start; rst=0 asserted mid-WAIT on another job → out_valid, start, busy and fifo_count clear immediately.

Source files
------------

// File: rtl/recur_job_dispatcher_pkg.sv
// Shared constants, state encoding and error value for the recurrence
// job dispatcher and the consumer of its results.
package recur_job_dispatcher_pkg;

    localparam int SIZE      = 4;
    localparam int MAX_ENTRY = 14;
    localparam int RES_W     = 2 * SIZE;

    localparam logic [RES_W-1:0] ERR_RESULT = '1;
    localparam logic [RES_W-1:0] ONE_RESULT = RES_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_GUARD  = 3'd2,
        S_WAIT   = 3'd3,
        S_RESULT = 3'd4
    } state_e;

endpackage

// File: rtl/recur_req_fifo.sv
// Request buffer in front of the dispatcher FSM.
// DEPTH must be a power of two so the pointers wrap on their own.
module recur_req_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     din_i,
    output logic [W-1:0]     dout_o,
    output logic [PTR_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rptr_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/recur_job_dispatcher.sv
// Queues entry requests and runs them one at a time on the recurrence
// core, short-circuiting trivial/illegal entries and hung jobs.
module recur_job_dispatcher
    import recur_job_dispatcher_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIZE-1:0]  in_entry,
    output logic             start,
    output logic [SIZE-1:0]  entry,
    input  logic             core_done,
    input  logic [RES_W-1:0] core_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIZE-1:0]  out_entry,
    output logic [RES_W-1:0] out_result,
    output logic             out_err,
    output logic             busy,
    output logic [PTR_W:0]   fifo_count
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [SIZE-1:0]   entry_q, entry_d;
    logic [SIZE-1:0]   oent_q, oent_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic              err_q, err_d;
    logic              vld_q, vld_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]   cnt_inc;
    logic              rdy_q;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [SIZE-1:0]   head;

    recur_req_fifo #(
        .W     (SIZE),
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid && in_ready),
        .pop_i   (pop),
        .din_i   (in_entry),
        .dout_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // rdy_q keeps in_ready low while reset is held and for no longer.
    assign in_ready   = rdy_q && !fifo_full;
    assign start      = (state_q == S_LAUNCH);
    assign busy       = (state_q != S_IDLE);
    assign entry      = entry_q;
    assign out_valid  = vld_q;
    assign out_entry  = oent_q;
    assign out_result = res_q;
    assign out_err    = err_q;
    assign cnt_inc    = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        oent_d  = oent_q;
        res_d   = res_q;
        err_d   = err_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !vld_q) begin
                    pop    = 1'b1;
                    oent_d = head;
                    if (head > SIZE'(MAX_ENTRY)) begin
                        res_d   = ERR_RESULT;
                        err_d   = 1'b1;
                        state_d = S_RESULT;
                    end else if (head <= SIZE'(1)) begin
                        res_d   = ONE_RESULT;
                        err_d   = 1'b0;
                        state_d = S_RESULT;
                    end else begin
                        entry_d = head;
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: state_d = S_GUARD;
            S_GUARD: begin
                // The core's done flag is stale here; never sample it.
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (core_done) begin
                    res_d   = core_result;
                    err_d   = 1'b0;
                    oent_d  = entry_q;
                    state_d = S_RESULT;
                end else if (cnt_inc == TO_W'(TIMEOUT)) begin
                    res_d   = ERR_RESULT;
                    err_d   = 1'b1;
                    oent_d  = entry_q;
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                if (!vld_q) begin
                    vld_d = 1'b1;
                end else if (out_ready) begin
                    vld_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            entry_q <= '0;
            oent_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            oent_q  <= oent_d;
            res_q   <= res_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            rdy_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_recur_job_dispatcher.sv
// Self-checking bench: vector table, corner sequences and a randomized
// run against a queue-based model with a recurrence core stand-in.
module tb_recur_job_dispatcher;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_entry = '0;
    logic       start;
    logic [3:0] entry;
    logic       core_done = 1'b0;
    logic [7:0] core_result = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_entry;
    logic [7:0] out_result;
    logic       out_err;
    logic       busy;
    logic [2:0] fifo_count;

    int tests = 0;
    int fails = 0;

    int core_delay = 1;
    int cur_delay = 1;
    bit core_hang = 1'b0;
    bit core_spur = 1'b0;
    bit rand_mode = 1'b0;
    int ss = -1;

    typedef struct {
        logic [3:0] e;
        int         delay;
        logic [7:0] res;
        logic       err;
        int         starts;
    } vec_t;

    vec_t       vecs [8];
    logic [3:0] exp_q [$];

    always #5 clk = ~clk;

    recur_job_dispatcher dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_entry    (in_entry),
        .start       (start),
        .entry       (entry),
        .core_done   (core_done),
        .core_result (core_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_entry   (out_entry),
        .out_result  (out_result),
        .out_err     (out_err),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    // a(n) = 2a(n-1) + 3a(n-2), a(0)=a(1)=1, kept to 8 bits.
    function automatic logic [7:0] ref_val(input int e);
        int a;
        int b;
        int c;
        if (e > 14) return 8'hFF;
        a = 1;
        b = 1;
        for (int i = 2; i <= e; i++) begin
            c = (2 * b + 3 * a) % 256;
            a = b;
            b = c;
        end
        return 8'(b);
    endfunction

    // Core stand-in: done in the delay-th WAIT cycle after start.
    always begin
        @(posedge clk);
        #1;
        if (!rst) begin
            ss = -1;
            core_done = 1'b0;
        end else begin
            core_done = 1'b0;
            if (start) begin
                ss = 0;
                cur_delay = rand_mode ? int'($urandom_range(1, 8))
                                      : core_delay;
            end else if (ss >= 0) begin
                ss++;
            end
            if (ss == 1 && core_spur) begin
                core_done = 1'b1;
                core_result = 8'h5A;
            end
            if (ss >= 2 && !core_hang && ss == 1 + cur_delay) begin
                core_done = 1'b1;
                core_result = ref_val(int'(entry));
                ss = -1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic wait_valid(input string nm, input int bound,
                              output int k, output int starts);
        k = 0;
        starts = 0;
        while (!out_valid && k < bound) begin
            if (start) starts++;
            tick();
            k++;
        end
        check(nm, 32'(out_valid), 32'd1);
    endtask

    task automatic handshake(input string nm);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check(nm, 32'(out_valid), 32'd0);
    endtask

    task automatic run_job(input vec_t v);
        int k;
        int starts;
        core_delay = v.delay;
        in_valid = 1'b1;
        in_entry = v.e;
        tick();
        in_valid = 1'b0;
        wait_valid("job_valid", 60, k, starts);
        if (v.starts == 0) check("trivial_latency", k, 2);
        check("job_result", out_result, v.res);
        check("job_err", out_err, v.err);
        check("job_entry", out_entry, v.e);
        check("job_starts", starts, v.starts);
        if (v.starts != 0) check("entry_hold", entry, v.e);
        handshake("job_release");
        check("job_idle", 32'(busy), 32'd0);
    endtask

    task automatic cmp_out(input string nm);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            check({nm, "_extra"}, exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            check({nm, "_result"}, out_result, ref_val(int'(e)));
            check({nm, "_err"}, 32'(out_err), 32'(e > 4'd14));
            check({nm, "_entry"}, out_entry, e);
        end
    endtask

    initial begin
        int k;
        int starts;
        int acc;
        int bad;
        vecs[0] = '{4'd4,  5, 8'd41,  1'b0, 1};
        vecs[1] = '{4'd0,  1, 8'd1,   1'b0, 0};
        vecs[2] = '{4'd1,  1, 8'd1,   1'b0, 0};
        vecs[3] = '{4'd15, 1, 8'hFF,  1'b1, 0};
        vecs[4] = '{4'd2,  1, 8'd5,   1'b0, 1};
        vecs[5] = '{4'd3,  3, 8'd13,  1'b0, 1};
        vecs[6] = '{4'd14, 2, 8'd189, 1'b0, 1};
        vecs[7] = '{4'd7,  4, 8'd69,  1'b0, 1};

        // reset state
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_start", 32'(start), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_err", 32'(out_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_entry", entry, 0);
        check("rst_out_entry", out_entry, 0);
        check("rst_out_result", out_result, 0);
        check("rst_fifo_count", fifo_count, 0);
        #1;
        rst = 1'b1;
        #1;
        check("rel_in_ready_before_edge", 32'(in_ready), 0);
        tick();
        check("rel_in_ready", 32'(in_ready), 1);

        for (int i = 0; i < 8; i++) run_job(vecs[i]);

        // FIFO fill with a stalled core, then reset mid-WAIT
        core_hang = 1'b1;
        acc = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_entry = 4'(2 + acc);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        check("fill_accepts", acc, 5);
        check("fill_count", fifo_count, 4);
        check("fill_in_ready", 32'(in_ready), 0);
        check("fill_busy", 32'(busy), 1);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_count", fifo_count, 0);
        check("midrst_start", 32'(start), 0);
        check("midrst_valid", 32'(out_valid), 0);
        tick();
        rst = 1'b1;
        core_hang = 1'b0;
        tick();
        check("midrst_in_ready", 32'(in_ready), 1);

        // spurious done in GUARD, then a hung core
        core_hang = 1'b1;
        core_spur = 1'b1;
        in_valid = 1'b1;
        in_entry = 4'd9;
        tick();
        in_valid = 1'b0;
        wait_valid("to_valid", 1200, k, starts);
        check("to_latency", k, 1027);
        check("to_err", 32'(out_err), 1);
        check("to_result", out_result, 8'hFF);
        check("to_entry", out_entry, 9);
        check("to_starts", starts, 1);
        handshake("to_release");
        core_hang = 1'b0;
        core_spur = 1'b0;

        // downstream back-pressure with a second job queued
        core_delay = 3;
        in_valid = 1'b1;
        in_entry = 4'd3;
        tick();
        in_entry = 4'd2;
        tick();
        in_valid = 1'b0;
        wait_valid("bp_valid", 40, k, starts);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_result !== 8'd13 || out_entry !== 4'd3 || out_err !== 1'b0
                || out_valid !== 1'b1 || start !== 1'b0)
                bad++;
            tick();
        end
        check("bp_stable_cycles", bad, 0);
        check("bp_queued", fifo_count, 1);
        handshake("bp_release");
        wait_valid("bp2_valid", 40, k, starts);
        check("bp2_result", out_result, 8'd5);
        check("bp2_entry", out_entry, 2);
        check("bp2_starts", starts, 1);
        handshake("bp2_release");

        // randomized traffic against the queue model
        rand_mode = 1'b1;
        core_spur = 1'b1;
        for (int c = 0; c < 600; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) cmp_out("rnd");
            if (start) begin
                check("rnd_launch_legal",
                      32'(entry >= 4'd2 && entry <= 4'd14), 1);
                if (exp_q.size() > 0) check("rnd_launch", entry, exp_q[0]);
            end
            in_valid = 1'($urandom_range(0, 1));
            in_entry = 4'($urandom_range(0, 15));
            if (in_valid && in_ready) exp_q.push_back(in_entry);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
            if (out_valid) cmp_out("drain");
            tick();
        end
        check("rnd_drained", exp_q.size(), 0);
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
